// File: rtl/div_iter_param.sv
// Iterative restoring divider retiring STEP quotient bits per clock.
// Produces {remainder, quotient} with divide-by-zero flag and busy indication.
module div_iter_param #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  localparam int NSTEP = WIDTH / STEP;
  localparam int CW    = $clog2(NSTEP);
  localparam logic [CW-1:0] LAST_CNT = CW'(NSTEP - 1);

  typedef enum logic [2:0] {
    S_FREE = 3'd0,
    S_DBZ  = 3'd1,
    S_ON   = 3'd2,
    S_FIX  = 3'd3,
    S_END  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_signed;
  logic               r_neg_a;
  logic               r_neg_b;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dz;
  logic               r_busy;

  logic               w_accept;
  logic               w_op2_zero;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_steps;

  // STEP chained restoring steps; the dividend register doubles as the quotient shifter.
  function automatic logic [2*WIDTH-1:0] div_steps(input logic [WIDTH-1:0] rem_in,
                                                   input logic [WIDTH-1:0] dvd_in,
                                                   input logic [WIDTH-1:0] dvs);
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH+1:0] diff;
    rem = rem_in;
    dvd = dvd_in;
    for (int i = 0; i < STEP; i++) begin
      diff = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dvs};
      if (!diff[WIDTH+1]) begin
        rem = diff[WIDTH-1:0];
        dvd = {dvd[WIDTH-2:0], 1'b1};
      end else begin
        rem = {rem[WIDTH-2:0], dvd[WIDTH-1]};
        dvd = {dvd[WIDTH-2:0], 1'b0};
      end
    end
    return {rem, dvd};
  endfunction

  // Operand magnitudes and sign fix-up of the finished quotient/remainder.
  always_comb begin
    w_accept   = start_i & ~annul_i;
    w_op2_zero = (opdata2_i == '0);
    w_abs1     = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    w_abs2     = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
    w_steps    = div_steps(r_rem, r_dvd, r_dvs);
    if (r_signed && (r_neg_a ^ r_neg_b)) begin
      w_quo_fix = ~r_dvd + 1'b1;
    end else begin
      w_quo_fix = r_dvd;
    end
    if (r_signed && r_neg_a) begin
      w_rem_fix = ~r_rem + 1'b1;
    end else begin
      w_rem_fix = r_rem;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_FREE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) begin
          w_next = w_op2_zero ? S_DBZ : S_ON;
        end else begin
          w_next = S_FREE;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_next = S_FREE;
        end else if (r_cnt == LAST_CNT) begin
          w_next = S_FIX;
        end else begin
          w_next = S_ON;
        end
      end
      S_FIX, S_DBZ: begin
        if (annul_i) begin
          w_next = S_FREE;
        end else begin
          w_next = S_END;
        end
      end
      S_END: begin
        if (start_i) begin
          w_next = S_END;
        end else begin
          w_next = S_FREE;
        end
      end
      default: w_next = S_FREE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_dz     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_busy <= (w_next == S_DBZ) || (w_next == S_ON) || (w_next == S_FIX);
      case (r_state)
        S_FREE: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          r_dz     <= 1'b0;
          if (w_accept) begin
            r_signed <= signed_div_i;
            r_neg_a  <= signed_div_i & opdata1_i[WIDTH-1];
            r_neg_b  <= signed_div_i & opdata2_i[WIDTH-1];
            r_dvd    <= w_abs1;
            r_dvs    <= w_abs2;
            // A zero divisor parks the raw dividend here for the defined remainder.
            r_rem    <= w_op2_zero ? opdata1_i : '0;
            r_cnt    <= '0;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            r_rem <= w_steps[2*WIDTH-1:WIDTH];
            r_dvd <= w_steps[WIDTH-1:0];
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (!annul_i) begin
            r_result <= {w_rem_fix, w_quo_fix};
            r_ready  <= 1'b1;
            r_dz     <= 1'b0;
          end
        end
        S_DBZ: begin
          if (!annul_i) begin
            r_result <= {r_rem, {WIDTH{1'b1}}};
            r_ready  <= 1'b1;
            r_dz     <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            r_result <= '0;
            r_ready  <= 1'b0;
            r_dz     <= 1'b0;
          end
        end
        default: begin
          r_result <= '0;
          r_ready  <= 1'b0;
          r_dz     <= 1'b0;
        end
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign busy_o     = r_busy;
  assign div_zero_o = r_dz;

endmodule

// File: tb/tb_div_iter_param.sv
// Self-checking bench: directed and random divides on three divider configurations
// against an arithmetic reference model.
module tb_div_iter_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        sg;
  logic        annul;
  logic [2:0]  start;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] res32;
  logic [31:0] res16a;
  logic [31:0] res16b;
  logic [2:0]  rdy;
  logic [2:0]  bsy;
  logic [2:0]  dz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_iter_param #(.WIDTH(32), .STEP(1)) u_w32 (
    .clk(clk), .rst(rst), .signed_div_i(sg), .start_i(start[0]), .annul_i(annul),
    .opdata1_i(op1), .opdata2_i(op2), .result_o(res32), .ready_o(rdy[0]),
    .busy_o(bsy[0]), .div_zero_o(dz[0]));

  div_iter_param #(.WIDTH(16), .STEP(2)) u_w16s2 (
    .clk(clk), .rst(rst), .signed_div_i(sg), .start_i(start[1]), .annul_i(annul),
    .opdata1_i(op1[15:0]), .opdata2_i(op2[15:0]), .result_o(res16a), .ready_o(rdy[1]),
    .busy_o(bsy[1]), .div_zero_o(dz[1]));

  div_iter_param #(.WIDTH(16), .STEP(4)) u_w16s4 (
    .clk(clk), .rst(rst), .signed_div_i(sg), .start_i(start[2]), .annul_i(annul),
    .opdata1_i(op1[15:0]), .opdata2_i(op2[15:0]), .result_o(res16b), .ready_o(rdy[2]),
    .busy_o(bsy[2]), .div_zero_o(dz[2]));

  function automatic int wid(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int stp(int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic logic [63:0] res_of(int k);
    case (k)
      0:       return res32;
      1:       return {32'h0, res16a};
      default: return {32'h0, res16b};
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended or zero-extended operands.
  task automatic ref_div(input int w, input bit s, input logic [31:0] a_in, input logic [31:0] b_in,
                         output logic [63:0] res, output bit z);
    logic [31:0] m;
    logic [31:0] a;
    logic [31:0] b;
    longint      la, lb, q, r;
    logic [63:0] qm, rm;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    a = a_in & m;
    b = b_in & m;
    z = (b == 32'h0);
    if (z) begin
      q = longint'(m);
      r = longint'(a);
    end else begin
      la = longint'(a);
      lb = longint'(b);
      if (s && a[w-1]) la = la - (64'sd1 <<< w);
      if (s && b[w-1]) lb = lb - (64'sd1 <<< w);
      q = la / lb;
      r = la % lb;
    end
    qm  = 64'(q) & {32'h0, m};
    rm  = 64'(r) & {32'h0, m};
    res = (rm << w) | qm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int k, input bit s, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble, input string tag);
    logic [63:0] er;
    bit          ez;
    int          edges, bn, explat;
    ref_div(wid(k), s, a, b, er, ez);
    sg       = s;
    op1      = a;
    op2      = b;
    start[k] = 1'b1;
    tick();
    edges = 1;
    bn    = 0;
    if (scramble) begin
      op1 = $urandom;
      op2 = $urandom;
      sg  = 1'($urandom_range(0, 1));
    end
    while (!rdy[k] && edges < 200) begin
      if (bsy[k]) bn++;
      tick();
      edges++;
    end
    explat = ez ? 2 : (wid(k) / stp(k) + 2);
    check_val({tag, " lat"}, 64'(edges), 64'(explat));
    check_val({tag, " busy"}, 64'(bn), 64'(explat - 1));
    check_val({tag, " res"}, res_of(k), er);
    check_val({tag, " dz"}, 64'(dz[k]), 64'(ez));
    if (!scramble) begin
      tick();
      check_val({tag, " hold"}, res_of(k), er);
    end
    start[k] = 1'b0;
    tick();
    check_val({tag, " clr flags"}, 64'({rdy[k], bsy[k], dz[k]}), 64'h0);
    check_val({tag, " clr res"}, res_of(k), 64'h0);
  endtask

  initial begin
    bit          seen;
    bit          s;
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    rst   = 1'b0;
    start = 3'b000;
    annul = 1'b0;
    sg    = 1'b0;
    op1   = 32'h0;
    op2   = 32'h0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) check_val("reset res", res_of(k), 64'h0);
    check_val("reset flags", 64'({rdy, bsy, dz}), 64'h0);
    rst = 1'b1;
    tick();

    run_op(0, 1'b0, 32'd100, 32'd7, 1'b0, "u100/7");
    run_op(0, 1'b1, 32'hFFFF_FFF9, 32'h2, 1'b0, "s-7/2");
    run_op(0, 1'b1, 32'h7, 32'hFFFF_FFFE, 1'b0, "s7/-2");
    run_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "smin/-1");
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, "umax/1");
    run_op(0, 1'b0, 32'h1234, 32'h0, 1'b0, "dbz");
    run_op(0, 1'b1, 32'hFFFF_FF00, 32'h0, 1'b0, "sdbz");

    // Annul in the middle of the iteration.
    sg       = 1'b0;
    op1      = 32'd100;
    op2      = 32'd7;
    start[0] = 1'b1;
    tick();
    repeat (10) tick();
    annul    = 1'b1;
    start[0] = 1'b0;
    tick();
    annul = 1'b0;
    check_val("annul flags", 64'({rdy[0], bsy[0]}), 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rdy[0]) seen = 1'b1;
    end
    check_val("annul no ready", 64'(seen), 64'h0);
    run_op(0, 1'b0, 32'd9, 32'd3, 1'b0, "after annul");

    // Reset in the middle of the iteration.
    sg       = 1'b1;
    op1      = 32'd1000;
    op2      = 32'd3;
    start[0] = 1'b1;
    tick();
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check_val("midrst flags", 64'({rdy[0], bsy[0], dz[0]}), 64'h0);
    check_val("midrst res", res_of(0), 64'h0);
    rst      = 1'b1;
    start[0] = 1'b0;
    tick();
    run_op(0, 1'b1, 32'hFFFF_FFEC, 32'd3, 1'b0, "after rst");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ((k == 0) ? 150 : 1000); i++) begin
        s   = 1'($urandom_range(0, 1));
        a   = $urandom;
        b   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
          0: b = 32'h0;
          1: b = 32'hFFFF_FFFF;
          2: b = 32'($urandom_range(1, 7));
          3: a = (k == 0) ? 32'h8000_0000 : 32'h0000_8000;
          4: b = b >> $urandom_range(0, 30);
          default: a = a;
        endcase
        run_op(k, s, a, b, 1'b1, "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
